// File: rtl/core_pkg.sv
// Shared writeback types: default widths, result source encodings, beat layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int RDW_DEF   = 5;

    typedef enum logic [1:0] {
        RS_ALU = 2'd0,
        RS_MEM = 2'd1,
        RS_PC4 = 2'd2,
        RS_IMM = 2'd3
    } result_src_e;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] result;
        logic [RDW_DEF-1:0]   rd;
        logic                 reg_write;
    } wb_beat_t;

    // Occupancy of the writeback elastic buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/result_sel.sv
// NSRC-way writeback source select; out-of-range selects give zero and raise sel_oob.
// Latency: combinational.
// Backpressure: none (no state).
module result_sel #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int SELW  = $clog2(NSRC)
) (
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      data,
    output logic                  sel_oob
);

    always_comb begin
        data    = '0;
        sel_oob = 1'b1;
        for (int k = 0; k < NSRC; k++) begin
            if (sel == SELW'(k)) begin
                data    = src_data[k*WIDTH +: WIDTH];
                sel_oob = 1'b0;
            end
        end
    end

endmodule

// File: rtl/wb_result_pipe.sv
// Registered writeback result mux feeding a two-entry (main + skid) elastic buffer.
// Latency: 1 cycle from accept to outputs; full throughput with out_ready high.
// Backpressure: in_ready depends only on state (low when both entries are full).
module wb_result_pipe
    import core_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NSRC  = 4,
    parameter int SELW  = $clog2(NSRC),
    parameter int RDW   = RDW_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [SELW-1:0]       result_src,
    input  logic [RDW-1:0]        in_rd,
    input  logic                  in_reg_write,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      result,
    output logic [RDW-1:0]        out_rd,
    output logic                  out_reg_write,
    output logic                  sel_err
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [RDW-1:0]   rd;
        logic             reg_write;
    } beat_t;

    pipe_state_e      state, state_nxt;
    beat_t            main_q, skid_q, beat_in;
    logic [WIDTH-1:0] sel_data;
    logic             sel_oob;
    logic             acc, drn;
    logic             load_main, load_skid, pop_skid;

    result_sel #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC),
        .SELW  (SELW)
    ) u_sel (
        .src_data (src_data),
        .sel      (result_src),
        .data     (sel_data),
        .sel_oob  (sel_oob)
    );

    always_comb begin
        beat_in           = '0;
        beat_in.result    = sel_data;
        beat_in.rd        = in_rd;
        beat_in.reg_write = in_reg_write;
    end

    assign in_ready      = (state != ST_TWO);
    assign out_valid     = (state != ST_EMPTY);
    assign acc           = in_valid && in_ready;
    assign drn           = out_valid && out_ready;
    assign result        = main_q.result;
    assign out_rd        = main_q.rd;
    assign out_reg_write = main_q.reg_write;

    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (acc) begin
                    state_nxt = ST_ONE;
                    load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (acc && drn) begin
                    load_main = 1'b1;
                end else if (acc) begin
                    state_nxt = ST_TWO;
                    load_skid = 1'b1;
                end else if (drn) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a drain can happen.
                if (drn) begin
                    state_nxt = ST_ONE;
                    pop_skid  = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            sel_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_main) begin
                main_q <= beat_in;
            end else if (pop_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= beat_in;
            end
            if (acc && sel_oob) begin
                sel_err <= 1'b1;
            end
        end
    end

endmodule
